// File: rtl/run_seq_ctrl.sv
// Run sequencer: clears the datapath, streams points into dist_calc,
// waits for distances and network sizes, then multiplies the sizes serially.
module run_seq_ctrl #(
  parameter int NUM_POINTS  = 20,
  parameter int DIM_W       = 17,
  parameter int NUM_NTWRKS  = 3,
  parameter int SZ_W        = $clog2(NUM_POINTS) + 1,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           core_clr,
  output logic                           pt_rd_en,
  output logic [$clog2(NUM_POINTS)-1:0]  pt_rd_addr,
  input  logic [3*DIM_W-1:0]             pt_rd_data,
  output logic [DIM_W-1:0]               xloc,
  output logic [DIM_W-1:0]               yloc,
  output logic [DIM_W-1:0]               zloc,
  output logic                           locs_vld,
  input  logic                           locs_rdy,
  input  logic                           dist_done,
  input  logic [NUM_NTWRKS*SZ_W-1:0]     ntwrk_sz,
  input  logic                           ntwrk_sz_vld,
  output logic [NUM_NTWRKS*SZ_W-1:0]     answer,
  output logic                           answer_vld,
  output logic                           err
);

  localparam int AW = $clog2(NUM_POINTS);
  localparam int AN = NUM_NTWRKS * SZ_W;
  localparam int KW = (NUM_NTWRKS > 1) ? $clog2(NUM_NTWRKS) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_RD, S_CAP, S_VLD,
    S_WDIST, S_WNET, S_MULT, S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_nxt;
  logic [AW-1:0]   r_idx;
  logic [KW-1:0]   r_k;
  logic [TW-1:0]   r_tmo;
  logic            r_done_seen;
  logic [AN-1:0]   r_szq;
  logic [AN-1:0]   r_acc;
  logic [AN-1:0]   r_answer;
  logic            r_ans_vld;
  logic            r_err;
  logic [DIM_W-1:0] r_x, r_y, r_z;

  logic            w_accept;
  logic            w_last;
  logic            w_klast;
  logic            w_tmo_hit;
  logic [AN-1:0]   w_sz;
  logic [AN-1:0]   w_prod;

  assign w_accept  = (r_state == S_VLD) && locs_rdy;
  assign w_last    = (r_idx == AW'(NUM_POINTS - 1));
  assign w_klast   = (r_k == KW'(NUM_NTWRKS - 1));
  assign w_sz      = AN'(r_szq[r_k*SZ_W +: SZ_W]);
  assign w_prod    = r_acc * w_sz;
  // Timeout only fires when the wait would otherwise continue this cycle
  assign w_tmo_hit = (r_tmo == TW'(TIMEOUT_CYC - 1)) &&
                     (((r_state == S_WDIST) && !r_done_seen) ||
                      ((r_state == S_WNET) && !ntwrk_sz_vld));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_nxt = S_CLR;
      S_CLR:   w_nxt = S_RD;
      S_RD:    w_nxt = S_CAP;
      S_CAP:   w_nxt = S_VLD;
      S_VLD:   if (w_accept) w_nxt = w_last ? S_WDIST : S_CAP;
      S_WDIST: if (r_done_seen) w_nxt = S_WNET;
               else if (w_tmo_hit) w_nxt = S_IDLE;
      S_WNET:  if (ntwrk_sz_vld) w_nxt = S_MULT;
               else if (w_tmo_hit) w_nxt = S_IDLE;
      S_MULT:  if (w_klast) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // The accept cycle already issues the next read, giving 2 cycles/point
  always_comb begin
    busy       = (r_state != S_IDLE);
    core_clr   = (r_state == S_CLR);
    locs_vld   = (r_state == S_VLD);
    pt_rd_en   = (r_state == S_RD) || (w_accept && !w_last);
    pt_rd_addr = (r_state == S_VLD) ? r_idx + AW'(1) : r_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_k         <= '0;
      r_tmo       <= '0;
      r_done_seen <= 1'b0;
      r_szq       <= '0;
      r_acc       <= AN'(1);
      r_answer    <= '0;
      r_ans_vld   <= 1'b0;
      r_err       <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_z         <= '0;
    end else begin
      r_done_seen <= (r_state == S_CLR) ? 1'b0 : (r_done_seen | dist_done);
      if ((r_state == S_IDLE) && start) begin
        r_ans_vld <= 1'b0;
        r_err     <= 1'b0;
        r_answer  <= '0;
      end
      if (r_state == S_CLR) begin
        r_idx <= '0;
        r_tmo <= '0;
      end
      if (r_state == S_CAP)
        {r_z, r_y, r_x} <= pt_rd_data;
      if (w_accept && !w_last)
        r_idx <= r_idx + AW'(1);
      if ((r_state == S_WDIST) || (r_state == S_WNET))
        r_tmo <= r_tmo + TW'(1);
      if (w_tmo_hit) begin
        r_err     <= 1'b1;
        r_ans_vld <= 1'b0;
      end
      if ((r_state == S_WNET) && ntwrk_sz_vld) begin
        r_szq <= ntwrk_sz;
        r_acc <= AN'(1);
        r_k   <= '0;
      end
      if (r_state == S_MULT) begin
        r_acc <= w_prod;
        r_k   <= r_k + KW'(1);
        if (w_klast) begin
          r_answer  <= w_prod;
          r_ans_vld <= 1'b1;
        end
      end
    end
  end

  assign xloc       = r_x;
  assign yloc       = r_y;
  assign zloc       = r_z;
  assign answer     = r_answer;
  assign answer_vld = r_ans_vld;
  assign err        = r_err;

endmodule

// File: tb/tb_run_seq_ctrl.sv
// Randomized bench for run_seq_ctrl against a point-stream and
// product-of-sizes reference model.
module tb_run_seq_ctrl;

  localparam int N   = 20;
  localparam int DW  = 17;
  localparam int NN  = 3;
  localparam int SZW = 6;
  localparam int AW  = 5;
  localparam int AN  = NN * SZW;
  localparam int TMO = 64;

  logic            clk = 1'b0;
  logic            rst, start, busy, core_clr, pt_rd_en;
  logic [AW-1:0]   pt_rd_addr;
  logic [3*DW-1:0] pt_rd_data;
  logic [DW-1:0]   xloc, yloc, zloc;
  logic            locs_vld, locs_rdy, dist_done;
  logic [AN-1:0]   ntwrk_sz;
  logic            ntwrk_sz_vld;
  logic [AN-1:0]   answer;
  logic            answer_vld, err;

  int n_run  = 0;
  int n_fail = 0;
  logic [3*DW-1:0] mem [N];

  run_seq_ctrl #(
    .NUM_POINTS(N), .DIM_W(DW), .NUM_NTWRKS(NN),
    .SZ_W(SZW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .core_clr(core_clr), .pt_rd_en(pt_rd_en),
    .pt_rd_addr(pt_rd_addr), .pt_rd_data(pt_rd_data),
    .xloc(xloc), .yloc(yloc), .zloc(zloc),
    .locs_vld(locs_vld), .locs_rdy(locs_rdy),
    .dist_done(dist_done), .ntwrk_sz(ntwrk_sz),
    .ntwrk_sz_vld(ntwrk_sz_vld), .answer(answer),
    .answer_vld(answer_vld), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous point buffer: data appears the cycle after the strobe
  always @(posedge clk)
    if (pt_rd_en && pt_rd_addr < AW'(N)) pt_rd_data <= mem[pt_rd_addr];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AN-1:0] model_ans(input logic [AN-1:0] s);
    longint p = 1;
    for (int k = 0; k < NN; k++) p = p * longint'(s[k*SZW +: SZW]);
    return p[AN-1:0];
  endfunction

  function automatic logic [AN-1:0] pack(input int a, input int b,
                                         input int c);
    return {SZW'(c), SZW'(b), SZW'(a)};
  endfunction

  function automatic logic [AN-1:0] rnd_sz();
    return pack($urandom_range(0, 63), $urandom_range(0, 63),
                $urandom_range(0, 63));
  endfunction

  task automatic run_one(input int pct, input bit early, input int dly,
                         input bit tmo, input int rst_pt, input bit hold,
                         input logic [AN-1:0] sz);
    int acc_n = 0, last = -1, dcyc = -1, ncyc = -1, clr_n = 0, rst_c = -1;
    int extra, lim;
    bit stall = 0, fin = 0;
    logic [3*DW-1:0] held = '0, w;
    logic [AN-1:0] exp_ans;
    logic [3:0] idle_exp;
    exp_ans = model_ans(sz);
    extra = $urandom_range(0, 4);
    ntwrk_sz = sz;
    @(negedge clk);
    start = 1; rst = 0; locs_rdy = 0; dist_done = 0; ntwrk_sz_vld = 0;
    for (int c = 1; c <= 1000 && !fin; c++) begin
      @(negedge clk);
      if (!hold || (ncyc >= 0 && c >= ncyc + 4)) start = 0;
      rst = 0;
      if (rst_c < 0 && rst_pt >= 0 && acc_n == rst_pt) begin
        rst = 1; start = 1; rst_c = c;
      end
      locs_rdy = ($urandom_range(0, 99) < pct);
      dist_done = 0;
      if (dcyc < 0 && ((early && acc_n == 10) ||
                       (!early && last >= 0 && c == last + dly))) begin
        dist_done = 1; dcyc = c;
      end
      ntwrk_sz_vld = 0;
      lim = (last > dcyc) ? last : dcyc;
      if (!tmo && ncyc < 0 && last >= 0 && dcyc >= 0 &&
          c == lim + 2 + extra) begin
        ntwrk_sz_vld = 1; ncyc = c;
      end
      #1;
      if (rst_c == c) continue;
      if (rst_c >= 0) begin
        check("rst_ctl", {busy, core_clr, pt_rd_en, locs_vld,
                          answer_vld, err, pt_rd_addr}, 0);
        check("rst_locs", {zloc, yloc, xloc}, 0);
        check("rst_ans", answer, 0);
        fin = 1;
        continue;
      end
      if (c == 1) begin
        check("clr_pulse", core_clr, 1);
        check("clr_flags", {answer_vld, err}, 0);
        check("clr_ans", answer, 0);
      end
      clr_n += int'(core_clr);
      w = {zloc, yloc, xloc};
      if (stall) begin
        check("stall_vld", locs_vld, 1);
        check("stall_data", w, held);
      end
      if (locs_vld && locs_rdy) begin
        if (acc_n < N) check($sformatf("pt%0d", acc_n), w, mem[acc_n]);
        else check("extra_acc", acc_n, N - 1);
        acc_n++;
        if (acc_n == N) last = c;
      end
      stall = locs_vld && !locs_rdy;
      held = w;
      if (ncyc >= 0) begin
        if (c == ncyc + 3) check("avld_early", answer_vld, 0);
        if (c == ncyc + 4) begin
          check("avld", answer_vld, 1);
          check("answer", answer, exp_ans);
          check("done_busy", busy, 1);
        end
        if (c == ncyc + 5) begin
          check("idle_busy", busy, 0);
          fin = 1;
        end
      end
      if (tmo && last >= 0) begin
        if (c == last + TMO) check("tmo_pre", {err, busy}, 2'b01);
        if (c == last + TMO + 1) begin
          check("tmo_err", {err, busy, answer_vld}, 3'b100);
          fin = 1;
        end
      end
    end
    check("run_bound", fin, 1);
    check("clr_count", clr_n, 1);
    if (rst_pt < 0) check("n_acc", acc_n, N);
    else check("n_acc_rst", acc_n, rst_pt);
    start = 0; rst = 0; locs_rdy = 0; dist_done = 0; ntwrk_sz_vld = 0;
    idle_exp = tmo ? 4'b0001 : ((rst_pt >= 0) ? 4'b0000 : 4'b0010);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("idle_hold", {busy, core_clr, answer_vld, err}, idle_exp);
    end
  endtask

  initial begin
    logic [63:0] r;
    for (int i = 0; i < N; i++) begin
      r = {$urandom, $urandom};
      mem[i] = r[3*DW-1:0];
    end
    rst = 1; start = 1; locs_rdy = 0; dist_done = 0;
    ntwrk_sz = '0; ntwrk_sz_vld = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ctl0", {busy, core_clr, pt_rd_en, locs_vld,
                       answer_vld, err, pt_rd_addr}, 0);
    check("rst_locs0", {zloc, yloc, xloc}, 0);
    check("rst_ans0", answer, 0);
    @(negedge clk);
    rst = 0; start = 0;
    ntwrk_sz = pack(3, 3, 3); ntwrk_sz_vld = 1;
    @(negedge clk);
    ntwrk_sz_vld = 0;
    #1;
    check("idle_ign", {busy, answer_vld}, 0);

    run_one(100, 0, 5, 0, -1, 0, pack(5, 4, 2));
    run_one(30, 0, 3, 0, -1, 0, rnd_sz());
    run_one(60, 1, 0, 0, -1, 0, rnd_sz());
    run_one(100, 0, 5, 1, -1, 0, pack(1, 2, 3));
    run_one(100, 0, 2, 0, -1, 0, rnd_sz());
    run_one(70, 0, 4, 0, 7, 0, rnd_sz());
    run_one(100, 0, 2, 0, -1, 0, pack(7, 9, 11));
    run_one(100, 0, 3, 0, -1, 1, pack(20, 0, 1));
    for (int i = 0; i < 4; i++)
      run_one($urandom_range(20, 100), 0, $urandom_range(1, 8),
              0, -1, 0, rnd_sz());

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule
